dz_countdown_scan: RTL

- Parametrised successor to the single-digit dot-matrix countdown game.
- Loads a start value, steps once per divided tick in down- or up-count mode, and supports pause/resume and restart.
- Drives an 8x8 two-colour dot matrix by row scanning: green normally, red in the warning zone, and blinking red on completion.
- Sits between the game's button/switch inputs and the board's matrix pins.

---
 rtl/dz_countdown_scan.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/dz_countdown_scan.sv
// dz_countdown_scan: single-digit count-down / count-up game timer.
// Drives an 8x8 two-colour dot matrix by row scanning.
// The digit is green normally and red in the warning zone.
// On completion the digit blinks red.
module dz_countdown_scan #(
    parameter int CNT_W     = 4,
    parameter int TICK_DIV  = 1000,
    parameter int SCAN_DIV  = 8,
    parameter int BLINK_DIV = 250,
    parameter int WARN      = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cst,
    input  logic             pause,
    input  logic             up_mode,
    input  logic [CNT_W-1:0] num,
    input  logic             dzst,
    output logic [7:0]       row,
    output logic [7:0]       colg,
    output logic [7:0]       colr,
    output logic             done,
    output logic [CNT_W-1:0] cnt_val
);

    localparam int TICK_W  = (TICK_DIV  > 1) ? $clog2(TICK_DIV)  : 1;
    localparam int SCAN_W  = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
    localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    localparam logic [CNT_W-1:0]   MAX_DIGIT  = CNT_W'(9);
    localparam logic [CNT_W-1:0]   WARN_V     = CNT_W'(WARN);
    localparam logic [TICK_W-1:0]  TICK_LAST  = TICK_W'(TICK_DIV - 1);
    localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_PAUSE,
        ST_DONE
    } state_t;

    state_t               state;
    logic [CNT_W-1:0]     num_l;
    logic                 mode_up;
    logic [TICK_W-1:0]    tick_cnt;
    logic [SCAN_W-1:0]    scan_cnt;
    logic [2:0]           scan_idx;
    logic [BLINK_W-1:0]   blink_cnt;
    logic                 blink_on;
    logic                 cst_prev;

    logic                 cst_edge;
    logic [CNT_W-1:0]     num_clamp;
    logic [CNT_W-1:0]     load_val;
    logic [CNT_W-1:0]     target;
    logic                 at_target;
    logic                 tick_due;
    logic [CNT_W-1:0]     step_val;
    logic [CNT_W-1:0]     remaining;
    logic                 warn_zone;
    logic [CNT_W-1:0]     disp_digit;
    logic [7:0]           glyph;
    logic [7:0]           row_nxt;
    logic [7:0]           colg_nxt;
    logic [7:0]           colr_nxt;

    // Glyph rows for digits 0-9; row 0 is the top byte, bit7 is the leftmost column.
    function automatic logic [7:0] font_row(input logic [3:0] d, input logic [2:0] r);
        logic [63:0] g;
        case (d)
            4'd0:    g = 64'h3C66_6666_6666_3C00;
            4'd1:    g = 64'h1838_1818_1818_3C00;
            4'd2:    g = 64'h3C66_060C_1830_7E00;
            4'd3:    g = 64'h3C66_061C_0666_3C00;
            4'd4:    g = 64'h0C1C_2C4C_7E0C_0C00;
            4'd5:    g = 64'h7E60_7C06_0666_3C00;
            4'd6:    g = 64'h3C60_607C_6666_3C00;
            4'd7:    g = 64'h7E06_0C18_3030_3000;
            4'd8:    g = 64'h3C66_663C_6666_3C00;
            4'd9:    g = 64'h3C66_663E_060C_3800;
            default: g = 64'h0;
        endcase
        return g[63 - 8*r -: 8];
    endfunction

    // Decode start edge, clamp, counting targets and colour choice from the registered state.
    always_comb begin
        cst_edge   = cst & ~cst_prev;
        num_clamp  = (num > MAX_DIGIT) ? MAX_DIGIT : num;
        load_val   = up_mode ? '0 : num_clamp;
        target     = mode_up ? num_l : '0;
        at_target  = (cnt_val == target);
        tick_due   = (tick_cnt == TICK_LAST);
        step_val   = mode_up ? (cnt_val + CNT_W'(1)) : (cnt_val - CNT_W'(1));
        remaining  = mode_up ? (num_l - cnt_val) : cnt_val;
        warn_zone  = (remaining <= WARN_V);
        disp_digit = (state == ST_IDLE) ? num_clamp : cnt_val;
        glyph      = font_row(4'(disp_digit), scan_idx);
    end

    // Next row/column values; the row and its column data come from the same scan index.
    always_comb begin
        row_nxt  = 8'hFF;
        colg_nxt = 8'h00;
        colr_nxt = 8'h00;
        if (dzst) begin
            row_nxt = ~(8'b1 << scan_idx);
            case (state)
                ST_DONE: colr_nxt = blink_on ? glyph : 8'h00;
                ST_RUN, ST_PAUSE: begin
                    if (warn_zone) colr_nxt = glyph;
                    else           colg_nxt = glyph;
                end
                default: colg_nxt = glyph;
            endcase
        end
    end

    // Remember the previous start input so a held level only triggers once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cst_prev <= 1'b0;
        else      cst_prev <= cst;
    end

    // Free-running row scan, independent of the game state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            scan_cnt <= '0;
            scan_idx <= 3'd0;
        end else if (scan_cnt == SCAN_LAST) begin
            scan_cnt <= '0;
            scan_idx <= scan_idx + 3'd1;
        end else begin
            scan_cnt <= scan_cnt + SCAN_W'(1);
        end
    end

    // Game FSM: a start edge always reloads; otherwise count, pause, or blink when done.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            cnt_val   <= '0;
            num_l     <= '0;
            mode_up   <= 1'b0;
            tick_cnt  <= '0;
            blink_cnt <= '0;
            blink_on  <= 1'b0;
            done      <= 1'b0;
        end else if (cst_edge) begin
            state    <= pause ? ST_PAUSE : ST_RUN;
            cnt_val  <= load_val;
            num_l    <= num_clamp;
            mode_up  <= up_mode;
            tick_cnt <= '0;
            done     <= 1'b0;
        end else begin
            case (state)
                ST_RUN, ST_PAUSE: begin
                    if (pause) begin
                        state <= ST_PAUSE;
                    end else if (at_target) begin
                        state     <= ST_DONE;
                        done      <= 1'b1;
                        blink_cnt <= '0;
                        blink_on  <= 1'b1;
                    end else begin
                        state <= ST_RUN;
                        if (tick_due) begin
                            tick_cnt <= '0;
                            cnt_val  <= step_val;
                            if (step_val == target) begin
                                state     <= ST_DONE;
                                done      <= 1'b1;
                                blink_cnt <= '0;
                                blink_on  <= 1'b1;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + TICK_W'(1);
                        end
                    end
                end
                ST_DONE: begin
                    if (blink_cnt == BLINK_LAST) begin
                        blink_cnt <= '0;
                        blink_on  <= ~blink_on;
                    end else begin
                        blink_cnt <= blink_cnt + BLINK_W'(1);
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Registered matrix drive.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            row  <= 8'hFF;
            colg <= 8'h00;
            colr <= 8'h00;
        end else begin
            row  <= row_nxt;
            colg <= colg_nxt;
            colr <= colr_nxt;
        end
    end

endmodule
